h264_bitstream_drain: RTL

- Reader side of the packer output buffer.
- After the packer signals the last 4x4 block of a frame, the block reads the buffered bitstream words over the h264_addr/h264_out port.
- It streams the words downstream on a valid/ready interface, then pulses h264_buf_clear so the buffer can be reused.
- It sits between the H.264 encoder core and the DMA/bus writer.

---
 rtl/h264_bitstream_drain.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/h264_bitstream_drain.sv
// h264_bitstream_drain
//
// Reader side of the packer output buffer. Once the packer flags the last
// 4x4 block of a frame, the buffered bitstream words are read back over
// h264_addr/h264_out and streamed downstream on a valid/ready port. After
// the final word has been accepted, h264_buf_clear pulses so the packer
// can reuse its buffer.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   h264_reset          encoder soft reset, same effect as rst
//   h264_enc_last4x4    frame-complete pulse from the packer
//   h264_buf_cnt        valid words in the packer buffer
//   h264_addr/h264_out  packer read port (data one cycle after address)
//   h264_buf_clear      one-cycle buffer-empty pulse
//   drain_busy          high from trigger until clear or abort
//   drain_ovf           sticky: h264_buf_cnt exceeded BUF_DEPTH
//   m_valid/m_ready/m_data/m_last  downstream stream
//
// Build option
//   H264_DRAIN_BYTESWAP_EN  byte-reverse each word (big-endian NAL order
//                           for a little-endian memory writer)
//
// FSM states
//   state   | meaning
//   IDLE    | waiting for h264_enc_last4x4
//   SNAP    | capture word count, issue read of address 0
//   READ    | issue reads while FIFO credit allows
//   FLUSH   | all reads issued, wait for last word to handshake
//   CLEAR   | pulse h264_buf_clear, drop busy next cycle

module h264_bitstream_drain #(
   parameter int BUF_DEPTH  = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        h264_reset,
   input  logic        h264_enc_last4x4,
   input  logic [31:0] h264_buf_cnt,
   output logic [7:0]  h264_addr,
   input  logic [31:0] h264_out,
   output logic        h264_buf_clear,
   output logic        drain_busy,
   output logic        drain_ovf,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic        m_last
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SNAP,
      S_READ,
      S_FLUSH,
      S_CLEAR
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] last_addr_q, last_addr_d;
   logic          inflight_q, inflight_d;
   logic          inflight_last_q, inflight_last_d;
   logic          clear_q, clear_d;
   logic          busy_q, busy_d;
   logic          ovf_q, ovf_d;

   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [31:0]   mem_d [FIFO_DEPTH];
   logic          tag_q [FIFO_DEPTH];
   logic          tag_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_idx_q, rd_idx_d;
   logic [CW-1:0] count_q, count_d;

   logic          soft_rst;
   logic [31:0]   n_words;
   logic [AW-1:0] snap_last;
   logic          credit_ok;
   logic          issue, issue_last;
   logic          push, pop;
   logic          head_last;
   logic [31:0]   push_data;

   function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign soft_rst  = rst | h264_reset;
   assign n_words   = (h264_buf_cnt > 32'(BUF_DEPTH)) ? 32'(BUF_DEPTH) : h264_buf_cnt;
   assign snap_last = AW'(n_words - 32'd1);

   // Words already queued plus the one still coming back from the packer
   // must leave room, so a returning word always finds a free slot.
   assign credit_ok = (32'(count_q) + 32'(inflight_q)) < 32'(FIFO_DEPTH);

   assign m_valid   = (count_q != '0);
   assign head_last = tag_q[rd_idx_q];
   assign pop       = m_valid & m_ready;
   assign push      = inflight_q;

`ifdef H264_DRAIN_BYTESWAP_EN
   assign push_data = {h264_out[7:0], h264_out[15:8], h264_out[23:16], h264_out[31:24]};
`else
   assign push_data = h264_out;
`endif

   generate
      if (AW >= 8) begin : g_addr_trunc
         assign h264_addr = rd_ptr_q[7:0];
      end else begin : g_addr_pad
         assign h264_addr = {{(8 - AW){1'b0}}, rd_ptr_q};
      end
   endgenerate

   assign m_data         = m_valid ? mem_q[rd_idx_q] : '0;
   assign m_last         = m_valid & head_last;
   assign h264_buf_clear = clear_q;
   assign drain_busy     = busy_q;
   assign drain_ovf      = ovf_q;

   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      last_addr_d = last_addr_q;
      busy_d      = busy_q;
      ovf_d       = ovf_q;
      clear_d     = 1'b0;
      issue       = 1'b0;
      issue_last  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (h264_enc_last4x4) begin
               state_d = S_SNAP;
               busy_d  = 1'b1;
            end
         end
         S_SNAP: begin
            if (h264_buf_cnt > 32'(BUF_DEPTH)) ovf_d = 1'b1;
            last_addr_d = snap_last;
            if (n_words == 32'd0) begin
               state_d = S_CLEAR;
               clear_d = 1'b1;
            end else begin
               // rd_ptr is parked at 0 while idle, so address 0 is already
               // on h264_addr; reading it here saves a cycle of startup.
               issue      = 1'b1;
               issue_last = (snap_last == '0);
               if (issue_last) begin
                  state_d  = S_FLUSH;
                  rd_ptr_d = '0;
               end else begin
                  state_d  = S_READ;
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         S_READ: begin
            if (credit_ok) begin
               issue      = 1'b1;
               issue_last = (rd_ptr_q == last_addr_q);
               if (issue_last) begin
                  state_d  = S_FLUSH;
                  rd_ptr_d = '0;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         S_FLUSH: begin
            if (pop && head_last && !inflight_q) begin
               state_d = S_CLEAR;
               clear_d = 1'b1;
            end
         end
         S_CLEAR: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      inflight_d      = issue;
      inflight_last_d = issue_last;
   end

   always_comb begin
      mem_d    = mem_q;
      tag_d    = tag_q;
      wr_ptr_d = wr_ptr_q;
      rd_idx_d = rd_idx_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         tag_d[wr_ptr_q] = inflight_last_q;
         wr_ptr_d        = nxt_ptr(wr_ptr_q);
      end
      if (pop) rd_idx_d = nxt_ptr(rd_idx_q);
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      // Storage needs no reset: count_q gates everything read from it.
      mem_q <= mem_d;
      tag_q <= tag_d;
      if (soft_rst) begin
         state_q         <= S_IDLE;
         rd_ptr_q        <= '0;
         last_addr_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         clear_q         <= 1'b0;
         busy_q          <= 1'b0;
         ovf_q           <= 1'b0;
         wr_ptr_q        <= '0;
         rd_idx_q        <= '0;
         count_q         <= '0;
      end else begin
         state_q         <= state_d;
         rd_ptr_q        <= rd_ptr_d;
         last_addr_q     <= last_addr_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         clear_q         <= clear_d;
         busy_q          <= busy_d;
         ovf_q           <= ovf_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_idx_q        <= rd_idx_d;
         count_q         <= count_d;
      end
   end

endmodule
